clks_alot_lock_ctrl: RTL and testbench

//  Lock/holdover controller for the clks_alot recovery path. Measures intervals between
//  pre-synchronised edge pulses and checks them against a configured period/tolerance window.

---
 rtl/clks_alot_lock_ctrl_if.sv | 10 +
 rtl/clks_alot_lock_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_clks_alot_lock_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clks_alot_lock_ctrl_if.sv
// Clock/reset domain bundle for the clks_alot lock controller.
// Ports: clk (rising-edge system clock), rst_n (asynchronous, active-low reset).
// The sink modport is what the controller consumes; the source drives both wires.
interface clks_alot_lock_ctrl_if;
  logic clk;
  logic rst_n;

  modport sink   (input  clk, input  rst_n);
  modport source (output clk, output rst_n);
endinterface

// File: rtl/clks_alot_lock_ctrl.sv
// Lock/holdover sequencer: measures edge intervals against a period/tolerance window and flywheels ticks.
// Latency: state/period/miss/pulse outputs registered (1 cycle after the causing edge); cfg_ready_o, locked_o decoded.
// Backpressure: config handshake accepted only in IDLE (cfg_ready_o); edge_i is never stalled, only rejected.
// Ports: sys_dom_i clk/rst_n; cfg_valid_i/cfg_ready_o/cfg_period_i/cfg_tol_i/cfg_err_o config; enable_i, edge_i run;
//        state_o, locked_o, period_o, miss_count_o status; expected_o, preempt_o, reject_o single-cycle pulses.
module clks_alot_lock_ctrl #(
  parameter int PERIOD_W     = 16,
  parameter int LOCK_COUNT   = 8,
  parameter int HOLDOVER_MAX = 4,
  parameter int PREEMPT_LEAD = 2
) (
  clks_alot_lock_ctrl_if.sink   sys_dom_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [PERIOD_W-1:0]   cfg_period_i,
  input  logic [PERIOD_W-1:0]   cfg_tol_i,
  output logic                  cfg_err_o,
  input  logic                  enable_i,
  input  logic                  edge_i,
  output logic [1:0]            state_o,
  output logic                  locked_o,
  output logic [PERIOD_W-1:0]   period_o,
  output logic [2:0]            miss_count_o,
  output logic                  expected_o,
  output logic                  preempt_o,
  output logic                  reject_o
);

  localparam int CW = PERIOD_W + 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] LEAD     = CW'(PREEMPT_LEAD);
  localparam logic [GW-1:0] LOCK_N   = GW'(LOCK_COUNT);
  localparam logic [2:0]    MISS_MAX = 3'(HOLDOVER_MAX);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]       good_q, good_d;
  logic                armed_q, armed_d;
  logic                configured_q, configured_d;
  logic                cfg_err_q, cfg_err_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] tol_q, tol_d;
  logic [2:0]          miss_q, miss_d;
  logic                expected_q, expected_d;
  logic                preempt_q, preempt_d;
  logic                reject_q, reject_d;

  logic [CW-1:0]       period_x, tol_x, diff, cnt_inc, period_dx;
  logic [CW:0]         sum_x;
  logic [CW-1:0]       avg;
  logic [PERIOD_W-1:0] period_avg;
  logic [GW-1:0]       good_inc;
  logic [2:0]          miss_inc;
  logic                in_win, miss_hit, cfg_fire, cfg_legal, tick_state;

  assign period_x = {1'b0, period_q};
  assign tol_x    = {1'b0, tol_q};
  // cnt_q on an edge cycle equals the interval since the previous accepted (or virtual) edge.
  assign diff     = (cnt_q >= period_x) ? (cnt_q - period_x) : (period_x - cnt_q);
  assign in_win   = (diff <= tol_x);
  assign miss_hit = (cnt_q == period_x + tol_x + CW'(1));
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  // Averaging sum kept one bit wider so a long in-window interval near full-scale period cannot wrap.
  assign sum_x      = {2'b00, period_q} + {1'b0, cnt_q};
  assign avg        = sum_x[CW:1];
  assign period_avg = avg[PERIOD_W] ? {PERIOD_W{1'b1}} : avg[PERIOD_W-1:0];
  assign good_inc   = good_q + GW'(1);
  assign miss_inc   = miss_q + 3'd1;
  assign cfg_fire   = cfg_valid_i && (state_q == ST_IDLE);
  assign cfg_legal  = (cfg_period_i >= PERIOD_W'(4)) && (cfg_tol_i < (cfg_period_i >> 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_inc;
    good_d       = good_q;
    armed_d      = armed_q;
    configured_d = configured_q;
    cfg_err_d    = cfg_err_q;
    period_d     = period_q;
    tol_d        = tol_q;
    miss_d       = miss_q;
    reject_d     = 1'b0;

    if (cfg_fire) begin
      if (cfg_legal) begin
        period_d     = cfg_period_i;
        tol_d        = cfg_tol_i;
        configured_d = 1'b1;
        cfg_err_d    = 1'b0;
      end else begin
        configured_d = 1'b0;
        cfg_err_d    = 1'b1;
      end
    end

    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      armed_d = 1'b0;
      good_d  = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (configured_q) begin
            state_d = ST_ACQUIRE;
            armed_d = 1'b0;
            good_d  = '0;
            miss_d  = '0;
          end
        end
        ST_ACQUIRE: begin
          if (edge_i) begin
            cnt_d = CW'(1);
            if (!armed_q) begin
              armed_d = 1'b1;
            end else if (in_win) begin
              good_d = good_inc;
              if (good_inc == LOCK_N) state_d = ST_LOCKED;
            end else begin
              good_d   = '0;
              reject_d = 1'b1;
            end
          end else if (armed_q && (cnt_q == CNT_MAX)) begin
            // Interval overflowed: the previous edge is no longer a usable reference.
            armed_d = 1'b0;
            good_d  = '0;
          end
        end
        default: begin
          if (miss_hit) begin
            // Window closed without an edge; any edge landing now is already out of window.
            reject_d = edge_i;
            if (miss_inc == MISS_MAX) begin
              state_d = ST_ACQUIRE;
              armed_d = 1'b0;
              good_d  = '0;
              miss_d  = '0;
              cnt_d   = '0;
            end else begin
              state_d = ST_HOLDOVER;
              miss_d  = miss_inc;
              // Re-time from a virtual edge at period_o, which was tol+1 cycles ago.
              cnt_d   = tol_x + CW'(2);
            end
          end else if (edge_i) begin
            if (in_win) begin
              state_d  = ST_LOCKED;
              cnt_d    = CW'(1);
              period_d = period_avg;
              miss_d   = '0;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Tick pulses are registered from next-state values so they line up with cnt_q == period_o.
  assign period_dx  = {1'b0, period_d};
  assign tick_state = (state_d == ST_LOCKED) || (state_d == ST_HOLDOVER);
  assign expected_d = tick_state && (cnt_d == period_dx);
  assign preempt_d  = tick_state && (period_dx > LEAD) && (cnt_d == period_dx - LEAD);

  always_ff @(posedge sys_dom_i.clk or negedge sys_dom_i.rst_n) begin
    if (!sys_dom_i.rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      good_q       <= '0;
      armed_q      <= 1'b0;
      configured_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      period_q     <= '0;
      tol_q        <= '0;
      miss_q       <= '0;
      expected_q   <= 1'b0;
      preempt_q    <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      armed_q      <= armed_d;
      configured_q <= configured_d;
      cfg_err_q    <= cfg_err_d;
      period_q     <= period_d;
      tol_q        <= tol_d;
      miss_q       <= miss_d;
      expected_q   <= expected_d;
      preempt_q    <= preempt_d;
      reject_q     <= reject_d;
    end
  end

  assign cfg_ready_o  = (state_q == ST_IDLE);
  assign locked_o     = (state_q == ST_LOCKED);
  assign state_o      = state_q;
  assign cfg_err_o    = cfg_err_q;
  assign period_o     = period_q;
  assign miss_count_o = miss_q;
  assign expected_o   = expected_q;
  assign preempt_o    = preempt_q;
  assign reject_o     = reject_q;

endmodule

// File: tb/tb_clks_alot_lock_ctrl.sv
// Bench for clks_alot_lock_ctrl: timed expectations are queued as stimulus is planned
// and compared by a negedge monitor when the DUT reaches the corresponding cycle.
// Cycle n = the interval between rising edge n and n+1; inputs driven in cycle n take effect in cycle n+1.
module tb_clks_alot_lock_ctrl;

  localparam int S_STATE = 0, S_LOCKED = 1, S_PERIOD = 2, S_MISS = 3, S_EXP = 4,
                 S_PRE = 5, S_REJ = 6, S_ERR = 7, S_RDY = 8;

  clks_alot_lock_ctrl_if sys_dom ();

  logic        cfg_valid, cfg_ready, cfg_err, enable, edge_pulse;
  logic [15:0] cfg_period, cfg_tol, period;
  logic [1:0]  state;
  logic        locked, expected, preempt, reject;
  logic [2:0]  miss_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;
  exp_t sb[$];

  clks_alot_lock_ctrl dut (
    .sys_dom_i    (sys_dom),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_period_i (cfg_period),
    .cfg_tol_i    (cfg_tol),
    .cfg_err_o    (cfg_err),
    .enable_i     (enable),
    .edge_i       (edge_pulse),
    .state_o      (state),
    .locked_o     (locked),
    .period_o     (period),
    .miss_count_o (miss_count),
    .expected_o   (expected),
    .preempt_o    (preempt),
    .reject_o     (reject)
  );

  initial begin
    sys_dom.clk = 1'b0;
    forever #5 sys_dom.clk = ~sys_dom.clk;
  end

  always @(posedge sys_dom.clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] peek(input int sel);
    case (sel)
      S_STATE:  peek = 32'(state);
      S_LOCKED: peek = 32'(locked);
      S_PERIOD: peek = 32'(period);
      S_MISS:   peek = 32'(miss_count);
      S_EXP:    peek = 32'(expected);
      S_PRE:    peek = 32'(preempt);
      S_REJ:    peek = 32'(reject);
      S_ERR:    peek = 32'(cfg_err);
      S_RDY:    peek = 32'(cfg_ready);
      default:  peek = 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input int v, input string tag);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.val = 32'(v);
    e.tag = $sformatf("%s@%0d", tag, c);
    sb.push_back(e);
  endtask

  always @(negedge sys_dom.clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, peek(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge sys_dom.clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_edge(input int c);
    wait_cyc(c);
    edge_pulse = 1'b1;
    tick();
    edge_pulse = 1'b0;
  endtask

  task automatic send_cfg(input int c, input int p, input int t);
    wait_cyc(c);
    cfg_valid  = 1'b1;
    cfg_period = 16'(p);
    cfg_tol    = 16'(t);
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_state"}, 32'(state), 0);
    chk({pfx, "_ready"}, 32'(cfg_ready), 1);
    chk({pfx, "_err"}, 32'(cfg_err), 0);
    chk({pfx, "_locked"}, 32'(locked), 0);
    chk({pfx, "_period"}, 32'(period), 0);
    chk({pfx, "_miss"}, 32'(miss_count), 0);
    chk({pfx, "_pulses"}, 32'({expected, preempt, reject}), 0);
  endtask

  // Nine edges 10 cycles apart from ACQUIRE: first arms, next eight fill the lock count.
  task automatic lock_seq(input int first);
    expect_at(first + 70, S_EXP, 0, "acq_no_expected");
    expect_at(first + 78, S_PRE, 0, "acq_no_preempt");
    expect_at(first + 21, S_REJ, 0, "acq_no_reject");
    expect_at(first + 80, S_STATE, 1, "acq_before_9th");
    expect_at(first + 81, S_STATE, 2, "locked_after_9th");
    expect_at(first + 81, S_LOCKED, 1, "locked_o");
    for (int k = 0; k < 9; k++) pulse_edge(first + 10 * k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: cycle=%0d still running, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_dom.rst_n = 1'b1;
    cfg_valid = 1'b0; cfg_period = '0; cfg_tol = '0; enable = 1'b0; edge_pulse = 1'b0;
    #1 sys_dom.rst_n = 1'b0;
    #2 reset_checks("rst0");
    wait_cyc(2);
    sys_dom.rst_n = 1'b1;

    // Legal config 10/1, then enable: ACQUIRE the cycle after configured is seen.
    expect_at(5, S_PERIOD, 10, "cfg_period");
    expect_at(5, S_ERR, 0, "cfg_err_ok");
    expect_at(5, S_STATE, 0, "idle_on_accept");
    expect_at(6, S_STATE, 1, "acquire");
    expect_at(6, S_RDY, 0, "ready_low_acq");
    send_cfg(4, 10, 1);
    enable = 1'b1;
    lock_seq(10);

    // Locked cadence with an extra early edge at interval 5.
    expect_at(98, S_PRE, 1, "preempt_lead");
    expect_at(99, S_EXP, 0, "exp_quiet_pre");
    expect_at(100, S_EXP, 1, "exp_on_edge");
    expect_at(101, S_EXP, 0, "exp_quiet_post");
    expect_at(108, S_PRE, 1, "preempt_lead2");
    expect_at(110, S_EXP, 1, "exp_on_edge2");
    expect_at(116, S_REJ, 1, "reject_early");
    expect_at(116, S_STATE, 2, "reject_state");
    expect_at(116, S_PERIOD, 10, "reject_period");
    expect_at(117, S_REJ, 0, "reject_one_cycle");
    expect_at(118, S_PRE, 1, "reject_cnt_kept_pre");
    expect_at(120, S_EXP, 1, "reject_cnt_kept_exp");
    expect_at(121, S_PERIOD, 10, "period_steady");
    pulse_edge(100);
    pulse_edge(110);
    pulse_edge(115);
    pulse_edge(120);

    // Edges stop after 120: misses at cnt 12 every 10 cycles, fourth drops to ACQUIRE.
    expect_at(130, S_EXP, 1, "fly_exp1");
    expect_at(132, S_STATE, 2, "still_locked");
    expect_at(132, S_MISS, 0, "miss0");
    expect_at(133, S_STATE, 3, "holdover");
    expect_at(133, S_MISS, 1, "miss1");
    expect_at(133, S_LOCKED, 0, "holdover_unlocked");
    expect_at(138, S_PRE, 1, "fly_pre");
    expect_at(140, S_EXP, 1, "fly_exp2");
    expect_at(143, S_MISS, 2, "miss2");
    expect_at(150, S_EXP, 1, "fly_exp3");
    expect_at(153, S_MISS, 3, "miss3");
    expect_at(160, S_EXP, 1, "fly_exp4");
    expect_at(162, S_STATE, 3, "holdover_last");
    expect_at(163, S_STATE, 1, "reacquire");
    expect_at(163, S_LOCKED, 0, "reacq_unlocked");
    expect_at(163, S_MISS, 0, "reacq_miss_clr");
    expect_at(163, S_EXP, 0, "reacq_no_exp");
    lock_seq(170);

    // One miss, then an edge 10 cycles after the virtual edge.
    expect_at(260, S_EXP, 1, "t4_exp");
    expect_at(263, S_STATE, 3, "t4_holdover");
    expect_at(263, S_MISS, 1, "t4_miss1");
    expect_at(270, S_EXP, 1, "t4_phase");
    expect_at(270, S_STATE, 3, "t4_hold_at_edge");
    expect_at(271, S_STATE, 2, "t4_relocked");
    expect_at(271, S_MISS, 0, "t4_miss_clr");
    expect_at(271, S_PERIOD, 10, "t4_period");
    expect_at(278, S_PRE, 1, "t4_pre");
    expect_at(280, S_EXP, 1, "t4_phase2");
    pulse_edge(270);
    pulse_edge(280);

    // Period tracking: intervals 11 then 9.
    expect_at(290, S_EXP, 1, "t2_exp");
    expect_at(291, S_EXP, 0, "t2_exp_off");
    expect_at(292, S_PERIOD, 10, "t2_avg_11");
    expect_at(292, S_STATE, 2, "t2_locked");
    expect_at(301, S_PERIOD, 9, "t2_avg_9");
    expect_at(301, S_STATE, 2, "t2_locked2");
    expect_at(307, S_PRE, 1, "t2_pre9");
    expect_at(309, S_EXP, 1, "t2_exp9");
    expect_at(316, S_PRE, 1, "t6_pre");
    expect_at(317, S_STATE, 2, "t6_locked");
    expect_at(318, S_STATE, 0, "t6_idle");
    expect_at(318, S_EXP, 0, "t6_exp_suppressed");
    expect_at(318, S_LOCKED, 0, "t6_unlocked");
    pulse_edge(291);
    pulse_edge(300);
    pulse_edge(309);
    wait_cyc(317);
    enable = 1'b0;

    // Illegal config holds IDLE; a legal one afterwards clears the error.
    expect_at(321, S_ERR, 1, "cfg_err_set");
    expect_at(321, S_PERIOD, 9, "cfg_err_period_kept");
    expect_at(321, S_STATE, 0, "cfg_err_idle");
    expect_at(324, S_STATE, 0, "cfg_err_no_run");
    expect_at(326, S_STATE, 0, "cfg_err_no_run2");
    expect_at(326, S_RDY, 1, "cfg_ready_idle");
    expect_at(331, S_ERR, 0, "cfg_err_clr");
    expect_at(331, S_PERIOD, 10, "cfg_reload");
    expect_at(331, S_STATE, 0, "cfg_reload_idle");
    expect_at(332, S_STATE, 1, "cfg_reload_acq");
    send_cfg(320, 2, 0);
    wait_cyc(322);
    enable = 1'b1;
    send_cfg(330, 10, 1);
    lock_seq(340);

    // Async reset while in HOLDOVER.
    expect_at(433, S_STATE, 3, "pre_rst_holdover");
    expect_at(435, S_STATE, 3, "pre_rst_holdover2");
    expect_at(435, S_MISS, 1, "pre_rst_miss");
    wait_cyc(436);
    #2 sys_dom.rst_n = 1'b0;
    #1 reset_checks("rst_mid");
    expect_at(440, S_STATE, 0, "post_rst_unconfigured");
    expect_at(440, S_PERIOD, 0, "post_rst_period");
    expect_at(442, S_STATE, 0, "post_rst_idle");
    expect_at(442, S_RDY, 1, "post_rst_ready");
    wait_cyc(438);
    sys_dom.rst_n = 1'b1;
    wait_cyc(445);

    chk("sb_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
